// File: rtl/spi_mem_host_ctrl_if.sv
// Parallel request/response handshake between a host and spi_mem_host_ctrl.
// The host side uses the master modport and the controller uses the slave modport.
interface spi_mem_host_ctrl_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_wr;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;

    modport master (
        output req_valid, req_wr, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/spi_mem_host_ctrl.sv
// Host-side controller for the single-port SPI memory: serializes op/address/write data onto cs/miso,
// collects LSB-first read data from mosi, and reports completion or error as a one-cycle response.
module spi_mem_host_ctrl #(
    parameter int ADDR_LIMIT = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic               clk,
    input  logic               rst,
    spi_mem_host_ctrl_if.slave bus,
    output logic               cs,
    output logic               miso,
    input  logic               mosi,
    input  logic               ready,
    input  logic               op_done
);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] CMD        = 3'd1;
    localparam logic [2:0] ADDR       = 3'd2;
    localparam logic [2:0] WDATA      = 3'd3;
    localparam logic [2:0] WAIT_WDONE = 3'd4;
    localparam logic [2:0] WAIT_RDY   = 3'd5;
    localparam logic [2:0] RDATA      = 3'd6;
    localparam logic [2:0] WAIT_RDONE = 3'd7;

    localparam int              WAIT_W    = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [8:0]      LIMIT     = 9'(ADDR_LIMIT);

    logic [2:0]        state;
    logic [2:0]        state_nx;
    logic [3:0]        bit_cnt;
    logic [3:0]        bit_cnt_nx;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_cnt_nx;
    logic              op_wr;
    logic              op_wr_nx;
    logic [7:0]        op_addr;
    logic [7:0]        op_addr_nx;
    logic [7:0]        op_wdata;
    logic [7:0]        op_wdata_nx;
    logic [7:0]        rdata;
    logic [7:0]        rdata_nx;
    logic              err_pend;
    logic              err_pend_nx;

    logic              cs_nx;
    logic              miso_nx;
    logic              req_ready_q;
    logic              req_ready_nx;
    logic              rsp_valid_q;
    logic              rsp_valid_nx;
    logic              rsp_err_q;
    logic              rsp_err_nx;
    logic [7:0]        rsp_rdata_q;
    logic [7:0]        rsp_rdata_nx;

    logic              accept;
    logic              in_range;
    logic              wait_expired;

    assign accept       = (state == IDLE) && req_ready_q && bus.req_valid;
    assign in_range     = ({1'b0, bus.req_addr} < LIMIT);
    assign wait_expired = (wait_cnt == WAIT_LAST);

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;

    // Next-state logic; every registered output is recomputed each cycle so the response is a single pulse.
    always_comb begin
        state_nx     = state;
        bit_cnt_nx   = bit_cnt;
        wait_cnt_nx  = wait_cnt;
        op_wr_nx     = op_wr;
        op_addr_nx   = op_addr;
        op_wdata_nx  = op_wdata;
        rdata_nx     = rdata;
        err_pend_nx  = 1'b0;
        cs_nx        = cs;
        miso_nx      = miso;
        rsp_valid_nx = 1'b0;
        rsp_err_nx   = 1'b0;
        rsp_rdata_nx = 8'h00;

        case (state)
            IDLE: begin
                cs_nx   = 1'b1;
                miso_nx = 1'b0;
                if (err_pend) begin
                    rsp_valid_nx = 1'b1;
                    rsp_err_nx   = 1'b1;
                end else if (accept) begin
                    if (in_range) begin
                        state_nx    = CMD;
                        cs_nx       = 1'b0;
                        miso_nx     = bus.req_wr;
                        op_wr_nx    = bus.req_wr;
                        op_addr_nx  = bus.req_addr;
                        op_wdata_nx = bus.req_wdata;
                        bit_cnt_nx  = 4'd0;
                        rdata_nx    = 8'h00;
                    end else begin
                        err_pend_nx = 1'b1;
                    end
                end
            end

            CMD: begin
                state_nx   = ADDR;
                bit_cnt_nx = 4'd0;
            end

            // bit_cnt[3] marks that all eight address bits have already been put on the wire.
            ADDR: begin
                if (bit_cnt[3]) begin
                    if (op_wr) begin
                        state_nx   = WDATA;
                        miso_nx    = op_wdata[0];
                        bit_cnt_nx = 4'd1;
                    end else begin
                        state_nx    = WAIT_RDY;
                        cs_nx       = 1'b1;
                        miso_nx     = 1'b0;
                        wait_cnt_nx = '0;
                    end
                end else begin
                    miso_nx    = op_addr[bit_cnt[2:0]];
                    bit_cnt_nx = bit_cnt + 4'd1;
                end
            end

            WDATA: begin
                if (bit_cnt[3]) begin
                    state_nx    = WAIT_WDONE;
                    cs_nx       = 1'b1;
                    miso_nx     = 1'b0;
                    wait_cnt_nx = '0;
                end else begin
                    miso_nx    = op_wdata[bit_cnt[2:0]];
                    bit_cnt_nx = bit_cnt + 4'd1;
                end
            end

            WAIT_WDONE: begin
                if (op_done) begin
                    state_nx     = IDLE;
                    rsp_valid_nx = 1'b1;
                end else if (wait_expired) begin
                    state_nx     = IDLE;
                    rsp_valid_nx = 1'b1;
                    rsp_err_nx   = 1'b1;
                end else begin
                    wait_cnt_nx = wait_cnt + 1'b1;
                end
            end

            // A completion pulse before all read bits arrived means the memory and controller disagree.
            WAIT_RDY: begin
                if (op_done || (!ready && wait_expired)) begin
                    state_nx     = IDLE;
                    rsp_valid_nx = 1'b1;
                    rsp_err_nx   = 1'b1;
                end else if (ready) begin
                    state_nx   = RDATA;
                    rdata_nx   = {7'b0, mosi};
                    bit_cnt_nx = 4'd1;
                end else begin
                    wait_cnt_nx = wait_cnt + 1'b1;
                end
            end

            RDATA: begin
                if (op_done) begin
                    state_nx     = IDLE;
                    rsp_valid_nx = 1'b1;
                    rsp_err_nx   = 1'b1;
                end else begin
                    rdata_nx[bit_cnt[2:0]] = mosi;
                    if (bit_cnt == 4'd7) begin
                        state_nx    = WAIT_RDONE;
                        wait_cnt_nx = '0;
                    end else begin
                        bit_cnt_nx = bit_cnt + 4'd1;
                    end
                end
            end

            WAIT_RDONE: begin
                if (op_done) begin
                    state_nx     = IDLE;
                    rsp_valid_nx = 1'b1;
                    rsp_rdata_nx = rdata;
                end else if (wait_expired) begin
                    state_nx     = IDLE;
                    rsp_valid_nx = 1'b1;
                    rsp_err_nx   = 1'b1;
                end else begin
                    wait_cnt_nx = wait_cnt + 1'b1;
                end
            end

            default: begin
                state_nx = IDLE;
                cs_nx    = 1'b1;
                miso_nx  = 1'b0;
            end
        endcase

        req_ready_nx = (state_nx == IDLE) && !err_pend_nx;
    end

    // Reset drops the bus immediately so the memory never sees a half-finished frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            bit_cnt     <= 4'd0;
            wait_cnt    <= '0;
            op_wr       <= 1'b0;
            op_addr     <= 8'h00;
            op_wdata    <= 8'h00;
            rdata       <= 8'h00;
            err_pend    <= 1'b0;
            cs          <= 1'b1;
            miso        <= 1'b0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 8'h00;
        end else begin
            state       <= state_nx;
            bit_cnt     <= bit_cnt_nx;
            wait_cnt    <= wait_cnt_nx;
            op_wr       <= op_wr_nx;
            op_addr     <= op_addr_nx;
            op_wdata    <= op_wdata_nx;
            rdata       <= rdata_nx;
            err_pend    <= err_pend_nx;
            cs          <= cs_nx;
            miso        <= miso_nx;
            req_ready_q <= req_ready_nx;
            rsp_valid_q <= rsp_valid_nx;
            rsp_err_q   <= rsp_err_nx;
            rsp_rdata_q <= rsp_rdata_nx;
        end
    end

endmodule

// File: tb/tb_spi_mem_host_ctrl.sv
// Directed, table-driven bench for spi_mem_host_ctrl with a cycle-scheduled SPI memory model
// driven relative to the acceptance edge.
module tb_spi_mem_host_ctrl;

    localparam int MEM_OK         = 0;
    localparam int MEM_NO_DONE    = 1;
    localparam int MEM_EARLY_DONE = 2;
    localparam int MEM_NO_RDY     = 3;
    localparam int MAX_CYCLES     = 40;
    localparam int NUM_VECS       = 14;

    typedef struct {
        string       name;
        logic        wr;
        logic [7:0]  addr;
        logic [7:0]  wdata;
        int          mode;
        logic        noise;
        int          exp_cycle;
        logic        exp_err;
        logic [7:0]  exp_rdata;
        int          exp_cs_low;
        logic [19:0] exp_miso;
    } vec_t;

    logic clk     = 1'b0;
    logic rst     = 1'b0;
    logic cs;
    logic miso;
    logic mosi    = 1'b0;
    logic ready   = 1'b0;
    logic op_done = 1'b0;

    int checks = 0;
    int fails  = 0;

    logic [7:0] mem_model [0:255];
    vec_t       vecs [NUM_VECS];

    spi_mem_host_ctrl_if bus();

    spi_mem_host_ctrl #(
        .ADDR_LIMIT(32),
        .TIMEOUT   (16)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .cs     (cs),
        .miso   (miso),
        .mosi   (mosi),
        .ready  (ready),
        .op_done(op_done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string what, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", what, actual, expected);
        end
    endtask

    // Memory behaviour for cycle c after acceptance (nominal schedule from the timing description).
    task automatic driveMemory(input vec_t v, input int c);
        logic [7:0] byte_val;
        ready   = 1'b0;
        op_done = 1'b0;
        mosi    = 1'b0;
        if (v.noise && c < (v.wr ? 18 : 10)) begin
            ready   = 1'b1;
            op_done = 1'b1;
            mosi    = 1'b1;
        end
        if (v.wr) begin
            if (v.mode == MEM_OK && c == 19) begin
                op_done            = 1'b1;
                mem_model[v.addr]  = v.wdata;
            end
        end else if (v.mode == MEM_EARLY_DONE) begin
            if (c == 11) op_done = 1'b1;
        end else if (v.mode != MEM_NO_RDY) begin
            if (c >= 12 && c <= 19) begin
                byte_val = mem_model[v.addr];
                ready    = 1'b1;
                mosi     = byte_val[3'(c - 12)];
            end
            if (v.mode == MEM_OK && c == 20) op_done = 1'b1;
        end
    endtask

    task automatic applyStimulus(input vec_t v, input bit hold);
        int          wait_n       = 0;
        int          rsp_cycle    = -1;
        int          cs_low       = 0;
        int          ready_busy   = 0;
        logic        rsp_err_seen = 1'b0;
        logic [7:0]  rsp_rd_seen  = 8'h00;
        logic        ready_at_rsp = 1'b0;
        logic [19:0] miso_seen    = '0;

        while (!bus.req_ready && wait_n < 20) begin
            @(negedge clk);
            wait_n++;
        end
        checkOutput({v.name, " req_ready_before_accept"}, int'(bus.req_ready), 1);

        bus.req_valid = 1'b1;
        bus.req_wr    = v.wr;
        bus.req_addr  = v.addr;
        bus.req_wdata = v.wdata;
        @(posedge clk);
        #1;
        if (!hold) bus.req_valid = 1'b0;

        for (int c = 0; c < MAX_CYCLES; c++) begin
            driveMemory(v, c);
            @(negedge clk);
            if (c < 20) miso_seen[5'(c)] = miso;
            if (!cs) cs_low++;
            if (bus.rsp_valid) begin
                rsp_cycle    = c;
                rsp_err_seen = bus.rsp_err;
                rsp_rd_seen  = bus.rsp_rdata;
                ready_at_rsp = bus.req_ready;
                break;
            end
            if (bus.req_ready) ready_busy++;
            @(posedge clk);
            #1;
        end
        ready   = 1'b0;
        op_done = 1'b0;
        mosi    = 1'b0;

        checkOutput({v.name, " rsp_cycle"},       rsp_cycle,           v.exp_cycle);
        checkOutput({v.name, " rsp_err"},         int'(rsp_err_seen),  int'(v.exp_err));
        checkOutput({v.name, " rsp_rdata"},       int'(rsp_rd_seen),   int'(v.exp_rdata));
        checkOutput({v.name, " cs_low_cycles"},   cs_low,              v.exp_cs_low);
        checkOutput({v.name, " miso_sequence"},   int'(miso_seen),     int'(v.exp_miso));
        checkOutput({v.name, " req_ready_busy"},  ready_busy,          0);
        checkOutput({v.name, " req_ready_at_rsp"}, int'(ready_at_rsp), 1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   rsp_pulses;
        vec_t v;

        for (int i = 0; i < 256; i++) mem_model[i] = 8'h00;

        // miso bit i is the level in cycle i after acceptance
        vecs[0]  = '{"wr_03_a5",     1'b1, 8'h03, 8'hA5, MEM_OK,         1'b0, 20, 1'b0, 8'h00, 18, 20'h2940F};
        vecs[1]  = '{"rd_03_noise",  1'b0, 8'h03, 8'h00, MEM_OK,         1'b1, 21, 1'b0, 8'hA5, 10, 20'h0000C};
        vecs[2]  = '{"range_28",     1'b0, 8'h28, 8'h00, MEM_OK,         1'b0,  1, 1'b1, 8'h00,  0, 20'h00000};
        vecs[3]  = '{"range_20_wr",  1'b1, 8'h20, 8'h11, MEM_OK,         1'b0,  1, 1'b1, 8'h00,  0, 20'h00000};
        vecs[4]  = '{"range_ff",     1'b0, 8'hFF, 8'h00, MEM_OK,         1'b0,  1, 1'b1, 8'h00,  0, 20'h00000};
        vecs[5]  = '{"wr_timeout",   1'b1, 8'h05, 8'h0F, MEM_NO_DONE,    1'b0, 34, 1'b1, 8'h00, 18, 20'h03C17};
        vecs[6]  = '{"rd_after_to",  1'b0, 8'h03, 8'h00, MEM_OK,         1'b0, 21, 1'b0, 8'hA5, 10, 20'h0000C};
        vecs[7]  = '{"wr_1f_noise",  1'b1, 8'h1F, 8'h5A, MEM_OK,         1'b1, 20, 1'b0, 8'h00, 18, 20'h1687F};
        vecs[8]  = '{"rd_1f",        1'b0, 8'h1F, 8'h00, MEM_OK,         1'b0, 21, 1'b0, 8'h5A, 10, 20'h0007C};
        vecs[9]  = '{"rd_early_done",1'b0, 8'h07, 8'h00, MEM_EARLY_DONE, 1'b0, 12, 1'b1, 8'h00, 10, 20'h0001C};
        vecs[10] = '{"rd_no_ready",  1'b0, 8'h02, 8'h00, MEM_NO_RDY,     1'b0, 26, 1'b1, 8'h00, 10, 20'h00008};
        vecs[11] = '{"rd_no_done",   1'b0, 8'h03, 8'h00, MEM_NO_DONE,    1'b0, 36, 1'b1, 8'h00, 10, 20'h0000C};
        vecs[12] = '{"wr_00_ff",     1'b1, 8'h00, 8'hFF, MEM_OK,         1'b0, 20, 1'b0, 8'h00, 18, 20'h3FC03};
        vecs[13] = '{"rd_00",        1'b0, 8'h00, 8'h00, MEM_OK,         1'b0, 21, 1'b0, 8'hFF, 10, 20'h00000};

        bus.req_valid = 1'b0;
        bus.req_wr    = 1'b0;
        bus.req_addr  = 8'h00;
        bus.req_wdata = 8'h00;

        $display("[TB] reset checks");
        #12;
        checkOutput("reset cs",        int'(cs),            1);
        checkOutput("reset miso",      int'(miso),          0);
        checkOutput("reset req_ready", int'(bus.req_ready), 0);
        checkOutput("reset rsp_valid", int'(bus.rsp_valid), 0);
        checkOutput("reset rsp_rdata", int'(bus.rsp_rdata), 0);
        checkOutput("reset rsp_err",   int'(bus.rsp_err),   0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("release req_ready_low", int'(bus.req_ready), 0);
        @(negedge clk);
        checkOutput("release req_ready_high", int'(bus.req_ready), 1);
        checkOutput("release cs_high",        int'(cs),            1);

        $display("[TB] table vectors");
        for (int i = 0; i < NUM_VECS; i++) applyStimulus(vecs[i], 1'b0);

        $display("[TB] reset during address phase");
        while (!bus.req_ready) @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_wr    = 1'b1;
        bus.req_addr  = 8'h1F;
        bus.req_wdata = 8'h77;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        checkOutput("midreset cs_low_in_addr", int'(cs), 0);
        rst = 1'b0;
        #1;
        checkOutput("midreset cs_async",   int'(cs),   1);
        checkOutput("midreset miso_async", int'(miso), 0);
        bus.req_valid = 1'b1;
        bus.req_wr    = 1'b1;
        bus.req_addr  = 8'h1F;
        bus.req_wdata = 8'h3C;
        rsp_pulses = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.rsp_valid) rsp_pulses++;
        end
        rst = 1'b1;
        @(negedge clk);
        if (bus.rsp_valid) rsp_pulses++;
        checkOutput("midreset no_response", rsp_pulses, 0);

        v = '{"b2b_wr_1f_3c", 1'b1, 8'h1F, 8'h3C, MEM_OK, 1'b0, 20, 1'b0, 8'h00, 18, 20'h0F07F};
        applyStimulus(v, 1'b1);
        v = '{"b2b_rd_1f",    1'b0, 8'h1F, 8'h00, MEM_OK, 1'b0, 21, 1'b0, 8'h3C, 10, 20'h0007C};
        applyStimulus(v, 1'b1);
        bus.req_valid = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("final cs_idle", int'(cs), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/spi_mem_host_ctrl.md
# spi_mem_host_ctrl

Host-side controller for the single-port SPI memory. It accepts parallel read/write requests over a valid/ready handshake and serializes each one onto the memory's `cs`/`miso` lines (command, address LSB-first, write data LSB-first). For reads it deserializes the returned `mosi` byte, qualified by the memory's `ready`. It reports completion, or an error, as a one-cycle response.

## Interface
- `ADDR_LIMIT`, 32: number of valid memory words; requests with `req_addr >= ADDR_LIMIT` are rejected.
- `TIMEOUT`, 16: maximum cycles spent in any wait state before aborting with error.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller idle and able to accept.
- `req_wr`  in  1  1 = write, 0 = read.
- `req_addr`  in  8  word address.
- `req_wdata`  in  8  write data.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_rdata`  out  8  read data; valid with `rsp_valid` on reads, 0 on writes and errors.
- `rsp_err`  out  1  valid with `rsp_valid`; 1 on address range or timeout error.
- `cs`  out  1  active-low chip select to memory.
- `miso`  out  1  serial command/address/data to memory.
- `mosi`  in  1  serial read data from memory.
- `ready`  in  1  memory read-data-valid flag.
- `op_done`  in  1  memory one-cycle operation-complete pulse.

## Operation
- Reset (async, `rst`=0):
  - Outputs: `cs`=1, `miso`=0, `req_ready`=0, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0.
  - State IDLE, all counters 0.
  - `req_ready` goes 1 on the first edge after release.
- States: IDLE, CMD, ADDR, WDATA, WAIT_WDONE, WAIT_RDY, RDATA, WAIT_RDONE.
- IDLE:
  - `req_ready`=1, `cs`=1, `miso`=0.
  - On `req_valid` with `req_addr < ADDR_LIMIT`: latch the request, drive `cs`=0 and `miso`=`req_wr`, go to CMD.
  - On `req_valid` with `req_addr >= ADDR_LIMIT`: accept, pulse `rsp_valid` with `rsp_err`=1 on the next cycle, stay IDLE. `cs` never falls.
- CMD: hold `miso`=op bit for the second cycle, then go to ADDR.
- ADDR: drive `addr[0]`..`addr[7]`, one bit per cycle.
- After the last address bit:
  - Write: go to WDATA, drive `wdata[0]`..`wdata[7]`, then go to WAIT_WDONE.
  - Read: go to WAIT_RDY.
- `cs` rises on the first cycle after the last serial bit; `miso` returns to 0 at the same time.
- WAIT_WDONE: on sampling `op_done`=1, respond with `rsp_err`=0 and go to IDLE.
- WAIT_RDY: on the first sampled `ready`=1, capture `mosi` as `rdata[0]` and go to RDATA.
- RDATA:
  - Capture `rdata[1..7]` on the next 7 edges, LSB-first shift into bit position.
  - Then go to WAIT_RDONE.
- WAIT_RDONE: on sampling `op_done`=1, respond with captured `rsp_rdata` and go to IDLE.
- Timeout:
  - A wait-cycle counter resets on entry to each WAIT_* state.
  - When it reaches `TIMEOUT` with no event: respond with `rsp_err`=1, `rsp_rdata`=0, go to IDLE.
- `op_done` sampled in WAIT_RDY or RDATA (premature) is an error: respond with `rsp_err`=1, go to IDLE.
- `ready`/`op_done`/`mosi` are ignored in IDLE, CMD, ADDR and WDATA.
- `req_ready`=0 in every state except IDLE. No request queuing.

## Timing
- Acceptance edge = E0. `cs` is low and `miso`=op during cycles 0–1.
- Address bits occupy cycles 2–9. Write data occupies cycles 10–17.
- `cs`=1 from cycle 18 (write) or cycle 10 (read). This guarantees the memory sees `cs` high when it re-enters idle.
- Write latency:
  - Memory pulses `op_done` in cycle 19.
  - `rsp_valid` is high in cycle 20.
- Read latency:
  - Memory `ready` rises in cycle 12 with `mosi`=bit0; bits 1–7 follow in cycles 13–19.
  - `op_done` is high in cycle 20.
  - `rsp_valid` is high in cycle 21.
- Range-error latency: `rsp_valid` in cycle 1.
- Back-to-back: next acceptance no earlier than the edge after `rsp_valid`. `cs` is high for at least 1 cycle between transactions.
- Reset asserted mid-transaction: `cs`=1 and `miso`=0 immediately (asynchronous). No response is issued for the aborted request.

## Test plan
- Reset then release -> all outputs at reset values; `req_ready`=1 one cycle after release; `cs`=1.
- Write addr 0x03, data 0xA5 ->
  - `miso` sequence 1,1, 1,1,0,0,0,0,0,0, 1,0,1,0,0,1,0,1;
  - `cs` low for exactly 18 cycles;
  - `rsp_valid` in cycle 20, `rsp_err`=0.
- Read addr 0x03 after the above write -> `rsp_rdata`=0xA5, `rsp_err`=0, `rsp_valid` in cycle 21; `cs` low for exactly 10 cycles.
- Request addr 0x28 (40) -> `cs` stays 1; `rsp_valid` in cycle 1 with `rsp_err`=1.
- Memory model never pulses `op_done` on a write -> `rsp_err`=1 exactly `TIMEOUT` cycles after entering WAIT_WDONE; the next request succeeds.
- `rst` asserted during ADDR -> `cs`=1 and `miso`=0 asynchronously, no `rsp_valid`. After release, with `req_valid` held, a write then a read of addr 31 (data 0x3C) complete correctly back-to-back.
